// File: rtl/limn2600_icache_ctrl_if.sv
// Instruction cache controller bus bundle: fetch port, flush pulse, memory read bus and cache array port.
interface limn2600_icache_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cpu_req;
    logic [DATA_WIDTH-1:0] cpu_addr;
    logic                  cpu_ready;
    logic                  cpu_rvalid;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  flush;
    logic                  mem_req;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  cache_we;
    logic [DATA_WIDTH-1:0] cache_addr_in;
    logic [DATA_WIDTH-1:0] cache_data_in;
    logic [DATA_WIDTH-1:0] cache_addr_out;
    logic [DATA_WIDTH-1:0] cache_data_out;

    // Environment side: fetch unit, memory bus and the hashed data array.
    modport master (
        output cpu_req, cpu_addr, flush, mem_ack, mem_rdata, cache_data_out,
        input  cpu_ready, cpu_rvalid, cpu_rdata, mem_req, mem_addr,
               cache_we, cache_addr_in, cache_data_in, cache_addr_out
    );

    // Controller side.
    modport slave (
        input  cpu_req, cpu_addr, flush, mem_ack, mem_rdata, cache_data_out,
        output cpu_ready, cpu_rvalid, cpu_rdata, mem_req, mem_addr,
               cache_we, cache_addr_in, cache_data_in, cache_addr_out
    );
endinterface

// File: rtl/limn2600_icache_ctrl.sv
// Instruction cache sequencer: tag/valid array, hit/miss handling, refill and valid-clear sweep.
module limn2600_icache_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_ENTRIES = 1023,
    parameter int unsigned IDX_W       = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    limn2600_icache_ctrl_if.slave bus
);
    localparam int unsigned LAST_IDX = NUM_ENTRIES - 1;

    typedef enum logic [2:0] {
        ST_FLUSH, ST_IDLE, ST_LOOKUP, ST_MISS, ST_FILL, ST_RESP
    } state_e;

    // Same xor-shift/multiply hash as the data array, reduced modulo the slot count.
    function automatic logic [IDX_W-1:0] hash_idx(input logic [DATA_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] x;
        x = a;
        x = ((x >> 16) ^ x) * DATA_WIDTH'(32'h045d9f3b);
        x = ((x >> 16) ^ x) * DATA_WIDTH'(32'h045d9f3b);
        x = (x >> 16) ^ x;
        return IDX_W'(x % DATA_WIDTH'(NUM_ENTRIES));
    endfunction

    logic [DATA_WIDTH-1:0] tag_mem   [NUM_ENTRIES];
    logic                  valid_mem [NUM_ENTRIES];

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] tag_rd_q, tag_rd_d;
    logic                  vld_rd_q, vld_rd_d;
    logic                  ready_q, ready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  mem_req_q, mem_req_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [IDX_W-1:0]      cur_idx_c;

    assign cur_idx_c = hash_idx(bus.cpu_addr);

    // State and output registers; reset restarts the sweep and drops any bus request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FLUSH;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            addr_q       <= '0;
            idx_q        <= '0;
            tag_rd_q     <= '0;
            vld_rd_q     <= 1'b0;
            ready_q      <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            we_q         <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            addr_q       <= addr_d;
            idx_q        <= idx_d;
            tag_rd_q     <= tag_rd_d;
            vld_rd_q     <= vld_rd_d;
            ready_q      <= ready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            we_q         <= we_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    // Tag/valid array: cleared one slot per cycle by the sweep, written on refill.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_FLUSH) begin
                valid_mem[cnt_q] <= 1'b0;
            end else if (state_q == ST_FILL) begin
                valid_mem[idx_q] <= 1'b1;
                tag_mem[idx_q]   <= addr_q;
            end
        end
    end

    // Next-state logic; registered outputs are derived from the next state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        addr_d       = addr_q;
        idx_d        = idx_q;
        tag_rd_d     = tag_rd_q;
        vld_rd_d     = vld_rd_q;
        rdata_d      = rdata_q;

        if (bus.flush && (state_q != ST_FLUSH)) begin
            flush_pend_d = 1'b1;
        end

        case (state_q)
            ST_FLUSH: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(LAST_IDX)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.cpu_req && ready_q) begin
                    addr_d   = bus.cpu_addr;
                    idx_d    = cur_idx_c;
                    tag_rd_d = tag_mem[cur_idx_c];
                    vld_rd_d = valid_mem[cur_idx_c];
                    state_d  = ST_LOOKUP;
                end else if (flush_pend_q) begin
                    flush_pend_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = ST_FLUSH;
                end
            end
            ST_LOOKUP: begin
                if (vld_rd_q && (tag_rd_q == addr_q)) begin
                    rdata_d = bus.cache_data_out;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_MISS;
                end
            end
            ST_MISS: begin
                if (bus.mem_ack) begin
                    rdata_d = bus.mem_rdata;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: begin
                cnt_d   = '0;
                state_d = ST_FLUSH;
            end
        endcase

        ready_d    = (state_d == ST_IDLE) && !flush_pend_d;
        rvalid_d   = (state_d == ST_RESP);
        mem_req_d  = (state_d == ST_MISS);
        mem_addr_d = mem_req_d ? addr_d : '0;
        we_d       = (state_d == ST_FILL);
        wr_addr_d  = we_d ? addr_d : '0;
        wr_data_d  = we_d ? rdata_d : '0;
    end

    assign bus.cpu_ready      = ready_q;
    assign bus.cpu_rvalid     = rvalid_q;
    assign bus.cpu_rdata      = rdata_q;
    assign bus.mem_req        = mem_req_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.cache_we       = we_q;
    assign bus.cache_addr_in  = wr_addr_q;
    assign bus.cache_data_in  = wr_data_q;
    // The data array registers its read, so the key follows the live request while idle.
    assign bus.cache_addr_out = (state_q == ST_IDLE) ? bus.cpu_addr : addr_q;
endmodule

// File: tb/tb_limn2600_icache_ctrl.sv
// Bench for the instruction cache controller: behavioural data array, map-based reference model.
module tb_limn2600_icache_ctrl;
    localparam int unsigned N = 1023;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    limn2600_icache_ctrl_if #(.DATA_WIDTH(32)) bus ();

    limn2600_icache_ctrl #(
        .DATA_WIDTH (32),
        .NUM_ENTRIES(N),
        .IDX_W      (10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Slot index of an address: xor-shift/0x45d9f3b hash, modulo slot count.
    function automatic int unsigned idx_of(input logic [31:0] a);
        logic [31:0] x;
        x = a;
        x = ((x >> 16) ^ x) * 32'h045d9f3b;
        x = ((x >> 16) ^ x) * 32'h045d9f3b;
        x = (x >> 16) ^ x;
        return x % N;
    endfunction

    // Behavioural hashed data array with a one-cycle registered read.
    logic [31:0] cmem [N];
    always @(posedge clk) begin
        if (bus.cache_we) cmem[idx_of(bus.cache_addr_in)] <= bus.cache_data_in;
        bus.cache_data_out <= cmem[idx_of(bus.cache_addr_out)];
    end

    // Event counters for rvalid pulses and mem_req bursts.
    int   rv_cnt = 0;
    int   mreq_cnt = 0;
    logic mreq_prev = 1'b0;
    always @(posedge clk) begin
        if (bus.cpu_rvalid) rv_cnt <= rv_cnt + 1;
        if (bus.mem_req && !mreq_prev) mreq_cnt <= mreq_cnt + 1;
        mreq_prev <= bus.mem_req;
    end

    // Reference model: what each slot currently holds.
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_data  [N];
    int exp_rv = 0;
    int exp_mreq = 0;
    int base_rv = 0;
    int base_mreq = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        int unsigned i;
        i = idx_of(a);
        return m_valid[i] && (m_tag[i] == a);
    endfunction

    // Counts cycles with cpu_ready low, starting at the current sample.
    task automatic wait_ready(input string tag, input int exp_low);
        int n;
        n = 0;
        while (!bus.cpu_ready && n < 5000) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'(exp_low));
    endtask

    task automatic fetch(input logic [31:0] a, input int dly, input logic [31:0] d, input bit flush_mid);
        int unsigned i;
        bit hit;
        int n;
        i   = idx_of(a);
        hit = model_hit(a);
        n   = 0;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = a;
        while (!bus.cpu_ready && n < 5000) begin
            tick();
            n++;
        end
        if (!bus.cpu_ready) begin
            check("accept_timeout", 32'(bus.cpu_ready), 32'd1);
            bus.cpu_req = 1'b0;
            return;
        end
        tick();
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = $urandom();
        check("rvalid_early", 32'(bus.cpu_rvalid), 32'd0);
        if (hit) begin
            tick();
            check("hit_rvalid", 32'(bus.cpu_rvalid), 32'd1);
            check("hit_rdata", bus.cpu_rdata, m_data[i]);
            check("hit_no_memreq", 32'(bus.mem_req), 32'd0);
        end else begin
            tick();
            check("miss_memreq", 32'(bus.mem_req), 32'd1);
            check("miss_memaddr", bus.mem_addr, a);
            for (int k = 0; k < dly; k++) begin
                if (flush_mid && k == 0) bus.flush = 1'b1;
                tick();
                bus.flush = 1'b0;
                check("miss_hold", 32'(bus.mem_req), 32'd1);
            end
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = d;
            tick();
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom();
            check("fill_we", 32'(bus.cache_we), 32'd1);
            check("fill_addr", bus.cache_addr_in, a);
            check("fill_data", bus.cache_data_in, d);
            check("fill_memreq_drop", 32'(bus.mem_req), 32'd0);
            tick();
            check("miss_rvalid", 32'(bus.cpu_rvalid), 32'd1);
            check("miss_rdata", bus.cpu_rdata, d);
            check("resp_no_we", 32'(bus.cache_we), 32'd0);
            m_valid[i] = 1'b1;
            m_tag[i]   = a;
            m_data[i]  = d;
            exp_mreq++;
        end
        exp_rv++;
        tick();
        check("rvalid_one_cycle", 32'(bus.cpu_rvalid), 32'd0);
    endtask

    task automatic flush_pulse();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        // One idle cycle to take the pending flush, then the full sweep.
        wait_ready("flush_sweep_len", int'(N) + 1);
        model_clear();
    endtask

    function automatic logic [31:0] fresh_addr(input logic [31:0] start);
        logic [31:0] a;
        a = start;
        while (model_hit(a)) a = a + 32'd4;
        return a;
    endfunction

    logic [31:0] addr_a, addr_b, addr_m;
    logic [31:0] pool [8];

    initial begin
        bus.cpu_req   = 1'b0;
        bus.cpu_addr  = '0;
        bus.flush     = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        rst           = 1'b1;
        model_clear();

        // Reset state and post-reset sweep length.
        tick();
        rst = 1'b0;
        check("rst_ready", 32'(bus.cpu_ready), 32'd0);
        check("rst_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        check("rst_memreq", 32'(bus.mem_req), 32'd0);
        check("rst_we", 32'(bus.cache_we), 32'd0);
        check("rst_rdata", bus.cpu_rdata, 32'd0);
        base_rv   = rv_cnt;
        base_mreq = mreq_cnt;
        wait_ready("reset_sweep_len", int'(N));
        check("sweep_no_memreq", 32'(mreq_cnt - base_mreq), 32'd0);

        // Cold miss, then hit on the same word.
        fetch(32'h0000_1000, 3, 32'hDEAD_BEEF, 1'b0);
        fetch(32'h0000_1000, 0, 32'h0, 1'b0);

        // Flush, then the same fetch misses and re-reads the bus.
        flush_pulse();
        fetch(32'h0000_1000, 1, 32'h1234_5678, 1'b0);
        fetch(32'h0000_1000, 0, 32'h0, 1'b0);

        // Flush during a miss: refill and response finish first, then the sweep.
        addr_m = fresh_addr(32'h0000_5000);
        fetch(addr_m, 2, $urandom(), 1'b1);
        wait_ready("flush_after_miss_len", int'(N) + 1);
        model_clear();
        fetch(addr_m, 1, $urandom(), 1'b0);

        // Reset in the middle of a miss.
        addr_m = fresh_addr(32'h0000_7770);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = addr_m;
        tick();
        bus.cpu_req = 1'b0;
        tick();
        check("pre_rst_memreq", 32'(bus.mem_req), 32'd1);
        exp_mreq++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_miss_memreq", 32'(bus.mem_req), 32'd0);
        check("rst_miss_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        wait_ready("rst_miss_sweep_len", int'(N));
        model_clear();

        // Two addresses sharing one slot, fetched A, B, A.
        addr_a = 32'h0000_2000;
        addr_b = addr_a + 32'd4;
        while (idx_of(addr_b) != idx_of(addr_a)) addr_b = addr_b + 32'd4;
        fetch(addr_a, 1, 32'hAAAA_0001, 1'b0);
        fetch(addr_b, 2, 32'hBBBB_0002, 1'b0);
        fetch(addr_a, 0, 32'hAAAA_0003, 1'b0);
        fetch(addr_a, 0, 32'h0, 1'b0);

        // Randomized traffic over a small address pool that includes the colliding pair.
        pool[0] = addr_a;
        pool[1] = addr_b;
        for (int k = 2; k < 8; k++) pool[k] = {$urandom_range(0, 32'hFFFF), 16'h0} | (32'(k) << 2);
        for (int t = 0; t < 80; t++) begin
            fetch(pool[$urandom_range(0, 7)], int'($urandom_range(0, 4)), $urandom(), 1'b0);
            if ($urandom_range(0, 39) == 0) flush_pulse();
        end

        check("rvalid_count", 32'(rv_cnt - base_rv), 32'(exp_rv));
        check("memreq_count", 32'(mreq_cnt - base_mreq), 32'(exp_mreq));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
